// File: rtl/fetch_queue.sv
// Instruction fetch unit: owns the PC, issues sequential imem requests and
// buffers returned words with their PC in a small FIFO toward decode.
module fetch_queue #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         trigger,
  input  logic                         redirect_valid,
  input  logic [DATA_WIDTH-1:0]        redirect_pc,
  output logic                         imem_req,
  output logic [DATA_WIDTH-1:0]        imem_addr,
  input  logic [DATA_WIDTH-1:0]        imem_rdata,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  output logic [DATA_WIDTH-1:0]        instr,
  output logic [DATA_WIDTH-1:0]        instr_pc,
  output logic [DATA_WIDTH-1:0]        instr_pcplus4,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_WIDTH-1:0] infl_pc_q, infl_pc_d;
  logic                  inflight_q, inflight_d;
  logic                  kill_q, kill_d;
  logic [CW-1:0]         count_q, count_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;

  logic [DATA_WIDTH-1:0] word_q [DEPTH];
  logic [DATA_WIDTH-1:0] pc_q   [DEPTH];

  logic credit_ok;
  logic issue;
  logic push;
  logic pop;

  // Credits cover both buffered words and the one response still in flight
  assign credit_ok = (count_q + CW'(inflight_q)) < CW'(DEPTH);
  assign issue     = rst_n && trigger && !redirect_valid && credit_ok;
  assign push      = inflight_q && !kill_q;
  assign pop       = instr_valid && instr_ready;

  assign imem_req    = issue;
  assign imem_addr   = fetch_pc_q;
  assign instr_valid = count_q != '0;
  assign fifo_count  = count_q;

  assign instr         = instr_valid ? word_q[rd_ptr_q] : NOP;
  assign instr_pc      = instr_valid ? pc_q[rd_ptr_q] : '0;
  assign instr_pcplus4 = instr_pc + DATA_WIDTH'(4);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    infl_pc_d  = infl_pc_q;
    inflight_d = issue;
    kill_d     = redirect_valid;
    count_d    = count_q + CW'(push) - CW'(pop);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    wr_ptr_d   = wr_ptr_q + AW'(push);
    if (issue) begin
      fetch_pc_d = fetch_pc_q + DATA_WIDTH'(4);
      infl_pc_d  = fetch_pc_q;
    end
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~DATA_WIDTH'(3);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      infl_pc_q  <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      infl_pc_q  <= infl_pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Storage is masked by count, so it needs no reset
  always_ff @(posedge clk) begin
    if (push) begin
      word_q[wr_ptr_q] <= imem_rdata;
      pc_q[wr_ptr_q]   <= infl_pc_q;
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(push && count_q == CW'(DEPTH))
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a reference PC/credit model predicts
// every request, buffered entry and head output.
module tb_fetch_queue;

  localparam int          DW    = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        trigger;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pcplus4;
  logic [2:0]  fifo_count;

  int n_tests;
  int n_fail;

  logic [31:0] sb [$];
  bit          pend_v;
  logic [31:0] pend_pc;
  logic [31:0] m_pc;
  bit          exp_req;
  bit          seen_wrap;

  fetch_queue #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .RESET_PC(RPC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .trigger(trigger),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_pcplus4(instr_pcplus4),
    .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] fw(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  always @(posedge clk) begin
    imem_rdata <= imem_req ? fw(imem_addr) : 32'hBAD0_BAD0;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp,
               $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_addr", imem_addr, RPC);
      chk("rst_instr", instr, NOP);
      chk("rst_pc", instr_pc, 32'd0);
      chk("rst_pc4", instr_pcplus4, 32'd4);
      sb.delete();
      pend_v = 1'b0;
      m_pc   = RPC;
    end else begin
      exp_req = trigger && !redirect_valid
                && (sb.size() + int'(pend_v) < DEPTH);
      chk("req", 32'(imem_req), 32'(exp_req));
      chk("count", 32'(fifo_count), 32'(sb.size()));
      chk("valid", 32'(instr_valid), 32'(sb.size() != 0));
      if (exp_req) chk("addr", imem_addr, m_pc);
      if (sb.size() != 0) begin
        chk("head_pc", instr_pc, sb[0]);
        chk("head_instr", instr, fw(sb[0]));
        chk("head_pc4", instr_pcplus4, sb[0] + 32'd4);
        if (sb[0] == 32'hFFFF_FFFC) seen_wrap = 1'b1;
      end else begin
        chk("idle_instr", instr, NOP);
      end
      if (sb.size() != 0 && instr_ready) void'(sb.pop_front());
      if (redirect_valid) begin
        sb.delete();
        pend_v = 1'b0;
        m_pc   = redirect_pc & ~32'd3;
      end else begin
        if (pend_v) sb.push_back(pend_pc);
        pend_v  = exp_req;
        pend_pc = m_pc;
        if (exp_req) m_pc = m_pc + 32'd4;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_count(input int n, input int lim);
    for (int i = 0; i < lim && int'(fifo_count) != n; i++) cyc(1);
    if (int'(fifo_count) != n) chk("wait_tmo", 32'(fifo_count), 32'(n));
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    cyc(1);
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    seen_wrap      = 1'b0;
    pend_v         = 1'b0;
    m_pc           = RPC;
    rst_n          = 1'b0;
    trigger        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b0;
    cyc(3);
    rst_n       = 1'b1;
    trigger     = 1'b1;
    instr_ready = 1'b1;
    cyc(12);

    // stall with decode blocked, then drain
    instr_ready = 1'b0;
    cyc(10);
    chk("stall_count", 32'(fifo_count), 32'd4);
    chk("stall_req", 32'(imem_req), 32'd0);
    instr_ready = 1'b1;
    cyc(6);

    // flush with three buffered and one in flight
    instr_ready = 1'b0;
    redirect(32'h0000_0040);
    wait_count(3, 20);
    redirect(32'h0000_0103);
    chk("flush_count", 32'(fifo_count), 32'd0);
    chk("flush_addr", imem_addr, 32'h0000_0100);
    instr_ready = 1'b1;
    for (int i = 0; i < 10 && !instr_valid; i++) cyc(1);
    chk("flush_head", instr_pc, 32'h0000_0100);
    cyc(4);

    // PC wrap across the top of the address space
    redirect(32'hFFFF_FFF4);
    cyc(10);
    chk("wrap_seen", 32'(seen_wrap), 32'd1);

    // push and pop together at count 2, then redirect with a pop
    instr_ready = 1'b0;
    redirect(32'h0000_0200);
    wait_count(2, 20);
    instr_ready = 1'b1;
    cyc(3);
    chk("pp_count", 32'(fifo_count), 32'd2);
    redirect(32'h0000_0300);
    chk("rpop_count", 32'(fifo_count), 32'd0);
    cyc(6);

    // trigger low: stop issuing, let the buffer drain
    trigger = 1'b0;
    cyc(6);
    chk("drain_count", 32'(fifo_count), 32'd0);
    trigger = 1'b1;
    cyc(4);

    // asynchronous reset with a full buffer
    instr_ready = 1'b0;
    wait_count(4, 20);
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(instr_valid), 32'd0);
    chk("async_count", 32'(fifo_count), 32'd0);
    chk("async_req", 32'(imem_req), 32'd0);
    cyc(2);
    rst_n       = 1'b1;
    instr_ready = 1'b1;
    #1;
    chk("post_rst_req", 32'(imem_req), 32'd1);
    chk("post_rst_addr", imem_addr, RPC);
    cyc(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
